// File: rtl/bist_controller_if.sv
// Signal bundle between the BIST controller and its environment:
// run control, functional operands, CUT operands/response, and run status.
interface bist_controller_if;
    logic        start;
    logic        abort;
    logic [7:0]  x_in;
    logic [7:0]  y_in;
    logic [7:0]  dut_z;
    logic [7:0]  x_out;
    logic [7:0]  y_out;
    logic        testmode;
    logic        busy;
    logic        done;
    logic        pass;
    logic [7:0]  signature;
    logic [15:0] pat_cnt;

    modport master (
        output start, abort, x_in, y_in, dut_z,
        input  x_out, y_out, testmode, busy, done, pass, signature, pat_cnt
    );

    modport slave (
        input  start, abort, x_in, y_in, dut_z,
        output x_out, y_out, testmode, busy, done, pass, signature, pat_cnt
    );
endinterface

// File: rtl/bist_controller.sv
// Logic BIST controller: drives the CUT from a 16-bit LFSR, compacts its
// response into an 8-bit MISR and compares the signature with GOLDEN.
module bist_controller #(
    parameter int unsigned PATTERNS = 255,
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter logic [7:0]  GOLDEN   = 8'h00
) (
    input logic              clk,
    input logic              rst_n,
    bist_controller_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_RUN,
        ST_COMPARE,
        ST_DONE
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(PATTERNS - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] lfsr;
    logic [15:0] pat_cnt;
    logic [7:0]  misr;
    logic        pass;
    logic        drive;
    logic        busy;
    logic        aborting;

    always_comb begin
        state_next = state;
        drive      = 1'b0;
        busy       = 1'b0;
        aborting   = 1'b0;

        case (state)
            ST_IDLE:    if (bus.start) state_next = ST_SEED;
            ST_SEED:    state_next = ST_RUN;
            ST_RUN:     if (pat_cnt == LAST_CNT) state_next = ST_COMPARE;
            ST_COMPARE: state_next = ST_DONE;
            ST_DONE:    if (bus.start) state_next = ST_SEED;
            default:    state_next = ST_IDLE;
        endcase

        drive = (state == ST_RUN) || (state == ST_COMPARE);
        busy  = drive || (state == ST_SEED);

        // abort overrides every other transition, but only during a run
        if (bus.abort && busy) begin
            aborting   = 1'b1;
            state_next = ST_IDLE;
        end
    end

    always_comb begin
        bus.testmode  = drive;
        bus.x_out     = drive ? lfsr[7:0]  : bus.x_in;
        bus.y_out     = drive ? lfsr[15:8] : bus.y_in;
        bus.busy      = busy;
        bus.done      = (state == ST_DONE);
        bus.pass      = pass;
        bus.signature = misr;
        bus.pat_cnt   = pat_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr    <= SEED;
            misr    <= '0;
            pat_cnt <= '0;
            pass    <= 1'b0;
        end else if (aborting) begin
            pass <= 1'b0;
        end else begin
            case (state)
                ST_SEED: begin
                    lfsr    <= SEED;
                    misr    <= '0;
                    pat_cnt <= '0;
                    pass    <= 1'b0;
                end
                ST_RUN: begin
                    misr    <= {misr[6:0], 1'b0} ^ (misr[7] ? 8'h1D : 8'h00) ^ bus.dut_z;
                    lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                    pat_cnt <= pat_cnt + 16'd1;
                end
                ST_COMPARE: pass <= (misr == GOLDEN);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bist_controller.sv
// Directed-plus-random bench for bist_controller; a behavioural model
// predicts LFSR patterns and MISR signatures for a CUT computing x^y^key.
module tb_bist_controller;

    localparam int unsigned P  = 4;
    localparam logic [15:0] SD = 16'hACE1;

    // LFSR as polynomial arithmetic: tap mask 0xB400 = bits 15,13,12,10
    function automatic logic [15:0] lfsr_adv(input logic [15:0] v, input int unsigned n);
        int unsigned r = 32'(v);
        for (int unsigned i = 0; i < n; i++)
            r = ((r << 1) | 32'(^(r & 32'hB400))) & 32'hFFFF;
        return 16'(r);
    endfunction

    // MISR as GF(2^8) multiply-by-x modulo 0x11D, then add the response
    function automatic logic [7:0] model_sig(input logic [7:0] k, input int unsigned n);
        int unsigned m = 0;
        logic [15:0] l;
        for (int unsigned i = 0; i < n; i++) begin
            l = lfsr_adv(SD, i);
            m = m * 2;
            if (m >= 256) m = m ^ 32'h11D;
            m = m ^ 32'(l[7:0] ^ l[15:8] ^ k);
        end
        return 8'(m);
    endfunction

    localparam logic [7:0] GOLD = model_sig(8'h00, P);

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] x_in;
    logic [7:0] y_in;
    logic [7:0] key;
    logic [7:0] sig;
    int unsigned total = 0;
    int unsigned passes = 0;
    int unsigned fails = 0;

    bist_controller_if ifa ();
    bist_controller_if ifb ();

    assign ifa.start = start;
    assign ifa.abort = abort;
    assign ifa.x_in  = x_in;
    assign ifa.y_in  = y_in;
    assign ifa.dut_z = ifa.x_out ^ ifa.y_out ^ key;
    assign ifb.start = start;
    assign ifb.abort = abort;
    assign ifb.x_in  = x_in;
    assign ifb.y_in  = y_in;
    assign ifb.dut_z = ifb.x_out ^ ifb.y_out ^ key;

    bist_controller #(.PATTERNS(P), .SEED(SD), .GOLDEN(GOLD)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
    );

    bist_controller #(.PATTERNS(P), .SEED(SD), .GOLDEN(GOLD ^ 8'h01)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_run(input logic [7:0] k, input bit hold);
        logic [15:0] l;
        logic [7:0]  es;
        key   = k;
        x_in  = 8'($urandom);
        y_in  = 8'($urandom);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        chk("seed_busy", 16'(ifa.busy), 16'd1);
        chk("seed_done", 16'(ifa.done), 16'd0);
        chk("seed_tm", 16'(ifa.testmode), 16'd0);
        chk("seed_xpass", 16'(ifa.x_out), 16'(x_in));
        for (int unsigned i = 0; i < P; i++) begin
            @(negedge clk);
            l = lfsr_adv(SD, i);
            chk("run_x", 16'(ifa.x_out), 16'(l[7:0]));
            chk("run_y", 16'(ifa.y_out), 16'(l[15:8]));
            chk("run_tm", 16'(ifa.testmode), 16'd1);
            chk("run_busy", 16'(ifa.busy), 16'd1);
            chk("run_cnt", ifa.pat_cnt, 16'(i));
        end
        es = model_sig(k, P);
        l  = lfsr_adv(SD, P);
        @(negedge clk);
        chk("cmp_tm", 16'(ifa.testmode), 16'd1);
        chk("cmp_busy", 16'(ifa.busy), 16'd1);
        chk("cmp_done", 16'(ifa.done), 16'd0);
        chk("cmp_x", 16'(ifa.x_out), 16'(l[7:0]));
        chk("cmp_sig", 16'(ifa.signature), 16'(es));
        @(negedge clk);
        chk("done_done", 16'(ifa.done), 16'd1);
        chk("done_busy", 16'(ifa.busy), 16'd0);
        chk("done_tm", 16'(ifa.testmode), 16'd0);
        chk("done_xpass", 16'(ifa.x_out), 16'(x_in));
        chk("done_ypass", 16'(ifa.y_out), 16'(y_in));
        chk("done_cnt", ifa.pat_cnt, 16'(P));
        chk("done_sig", 16'(ifa.signature), 16'(es));
        chk("done_pass", 16'(ifa.pass), 16'(es == GOLD));
        chk("b_done", 16'(ifb.done), 16'd1);
        chk("b_pass", 16'(ifb.pass), 16'(es == (GOLD ^ 8'h01)));
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        key   = 8'h00;
        x_in  = 8'd159;
        y_in  = 8'd76;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_x", 16'(ifa.x_out), 16'd159);
        chk("rst_y", 16'(ifa.y_out), 16'd76);
        chk("rst_tm", 16'(ifa.testmode), 16'd0);
        chk("rst_busy", 16'(ifa.busy), 16'd0);
        chk("rst_done", 16'(ifa.done), 16'd0);
        chk("rst_pass", 16'(ifa.pass), 16'd0);
        chk("rst_sig", 16'(ifa.signature), 16'd0);
        chk("rst_cnt", ifa.pat_cnt, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 16'(ifa.busy), 16'd0);

        // golden signature match on dut_a, one-bit-off GOLDEN on dut_b
        do_run(8'h00, 1'b0);

        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_done_ign", 16'(ifa.done), 16'd1);
        chk("abort_done_pass", 16'(ifa.pass), 16'd1);
        chk("abort_done_cnt", ifa.pat_cnt, 16'(P));

        repeat (3) do_run(8'($urandom), 1'b0);

        // abort in the third RUN cycle
        key   = 8'($urandom);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pat0_x", 16'(ifa.x_out), 16'h00E1);
        chk("pat0_y", 16'(ifa.y_out), 16'h00AC);
        @(negedge clk);
        chk("pat1_x", 16'(ifa.x_out), 16'h00C3);
        chk("pat1_y", 16'(ifa.y_out), 16'h0059);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        sig = model_sig(key, 2);
        chk("abort_busy", 16'(ifa.busy), 16'd0);
        chk("abort_done", 16'(ifa.done), 16'd0);
        chk("abort_pass", 16'(ifa.pass), 16'd0);
        chk("abort_tm", 16'(ifa.testmode), 16'd0);
        chk("abort_cnt", ifa.pat_cnt, 16'd2);
        chk("abort_sig", 16'(ifa.signature), 16'(sig));
        chk("abort_xpass", 16'(ifa.x_out), 16'(x_in));

        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle_busy", 16'(ifa.busy), 16'd0);
        chk("abort_idle_cnt", ifa.pat_cnt, 16'd2);

        // asynchronous reset between edges in the middle of RUN
        key   = 8'($urandom);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 16'(ifa.busy), 16'd0);
        chk("arst_tm", 16'(ifa.testmode), 16'd0);
        chk("arst_done", 16'(ifa.done), 16'd0);
        chk("arst_pass", 16'(ifa.pass), 16'd0);
        chk("arst_sig", 16'(ifa.signature), 16'd0);
        chk("arst_cnt", ifa.pat_cnt, 16'd0);
        chk("arst_xpass", 16'(ifa.x_out), 16'(x_in));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_idle", 16'(ifa.busy), 16'd0);
        do_run(key, 1'b0);

        // start held through DONE: the second run's SEED follows immediately
        key = 8'($urandom);
        do_run(key, 1'b1);
        do_run(key, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
